shared_mem_ctrl: RTL and testbench

Parametrised memory subsystem for the next-generation MIPS core. It replaces the separate zero-latency instruction and data memories with one single-port word RAM. The RAM is shared by an instruction-fetch port and a load/store port through a fair arbiter, with a configurable number of wait states. It sits between the core and storage at the top level; the core stalls on each port until that port's ready pulse.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/sp_ram.sv | 28 ++
 rtl/shared_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_shared_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the shared instruction/data memory subsystem.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_e;

  // Lane count for the default 32-bit word; modules derive theirs from DATA_W.
  localparam int PKG_DATA_W = 32;
  localparam int BYTE_LANES = PKG_DATA_W / 8;

  // Word index from a byte address: drop addr[1:0], keep idx_w bits above them.
  function automatic logic [31:0] word_index(input logic [63:0] byte_addr, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((byte_addr >> 2) & mask);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM: synchronous per-lane write, combinational read so the
// controller can capture the word on the same edge that commits the access.
module sp_ram #(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int LANES       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LANES-1:0]  wmask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes; contents are never cleared
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we && wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared single-port memory controller: fair arbitration between the fetch
// port and the load/store port, WAIT_STATES extra cycles per access.
// Optional feature macro: BYTE_ENABLE_EN adds d_be and lane-masked stores.
module shared_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
`ifdef BYTE_ENABLE_EN
  input  logic [DATA_W/8-1:0] d_be,
`endif
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready
);

  localparam int         LANES = DATA_W / 8;
  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  gnt_e                last_q, last_d;      // current grant while busy, last served while idle
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]    be_q, be_d;
  logic                i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  gnt_e                req_gnt;
  logic [IDX_W-1:0]    i_idx, d_idx;
  logic [LANES-1:0]    d_be_in;
  logic                commit;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  assign i_idx = IDX_W'(word_index(64'(i_addr), IDX_W));
  assign d_idx = IDX_W'(word_index(64'(d_addr), IDX_W));

`ifdef BYTE_ENABLE_EN
  assign d_be_in = d_be;
`else
  assign d_be_in = '1;
`endif

  // Arbiter: a lone requester wins; on contention the port not served last wins
  always_comb begin
    req_gnt = GNT_D;
    if (i_req && d_req) req_gnt = (last_q == GNT_D) ? GNT_I : GNT_D;
    else if (i_req)     req_gnt = GNT_I;
  end

  // Next state, wait counter and latched request payload
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_d = req_gnt;
          cnt_d  = WS;
          if (req_gnt == GNT_D) begin
            addr_d  = d_idx;
            we_d    = d_we;
            wdata_d = d_wdata;
            be_d    = d_be_in;
          end else begin
            addr_d  = i_idx;
            we_d    = 1'b0;
          end
          state_d = (WS == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM is touched only on the edge that enters DONE; the *_d payload is
  // the fresh request when WAIT_STATES is 0 and the latched one otherwise.
  assign commit = (state_d == DONE) && (state_q != DONE);
  assign ram_we = commit && we_d && !reset;

  // Ready pulses and read-data capture for the granted port
  always_comb begin
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (commit) begin
      if (last_d == GNT_I) begin
        i_ready_d = 1'b1;
        i_rdata_d = ram_rdata;
      end else begin
        d_ready_d = 1'b1;
        if (!we_d) d_rdata_d = ram_rdata;
      end
    end
  end

  // Control and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= GNT_I;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Latched request payload, only meaningful while an access is in flight
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  sp_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_d),
    .wmask (be_d),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Bench for shared_mem_ctrl: one instance with WAIT_STATES=1 driven from a
// vector table plus corner sequences, one with WAIT_STATES=0 for back-to-back.
`timescale 1ns/1ps
module tb_shared_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_STATES = 1 instance
  logic        reset;
  logic        i_req, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
`ifdef BYTE_ENABLE_EN
  logic [3:0]  d_be;
`endif

  // WAIT_STATES = 0 instance
  logic        z_reset;
  logic        z_i_req, z_i_ready;
  logic [31:0] z_i_addr, z_i_rdata;
  logic        z_d_req, z_d_we, z_d_ready;
  logic [31:0] z_d_addr, z_d_wdata, z_d_rdata;
`ifdef BYTE_ENABLE_EN
  logic [3:0]  z_d_be;
`endif

  shared_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(64), .WAIT_STATES(1)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef BYTE_ENABLE_EN
    .d_be(d_be),
`endif
    .d_rdata(d_rdata), .d_ready(d_ready)
  );

  shared_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(z_reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_ready(z_i_ready),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
`ifdef BYTE_ENABLE_EN
    .d_be(z_d_be),
`endif
    .d_rdata(z_d_rdata), .d_ready(z_d_ready)
  );

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  int          np, t1, t2;
  logic [31:0] r1, r2;
  logic        flag;
  int          ptime [4];
  logic        pport [4];
  logic [31:0] prd   [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp);
    vec_t v;
    v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
    return v;
  endfunction

  // One access on the WAIT_STATES=1 instance: latency, data and pulse shape
  task automatic run_access(input int idx, input vec_t v);
    int          lat;
    logic        seen, other;
    logic [31:0] prev_d;
    prev_d = d_rdata;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
`ifdef BYTE_ENABLE_EN
      d_be = v.be;
`endif
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    lat = 0; seen = 1'b0; other = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (v.is_d ? i_ready : d_ready) other = 1'b1;
      if (v.is_d ? d_ready : i_ready) seen = 1'b1;
    end
    chk($sformatf("vec%0d latency", idx), 32'(lat), 32'd2);
    chk($sformatf("vec%0d other port ready", idx), 32'(other), 32'd0);
    if (v.is_d && v.we)  chk($sformatf("vec%0d d_rdata held on store", idx), d_rdata, prev_d);
    else if (v.is_d)     chk($sformatf("vec%0d d_rdata", idx), d_rdata, v.exp);
    else                 chk($sformatf("vec%0d i_rdata", idx), i_rdata, v.exp);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk($sformatf("vec%0d ready is one cycle", idx), 32'(v.is_d ? d_ready : i_ready), 32'd0);
  endtask

  task automatic z_store(input logic [31:0] a, input logic [31:0] w);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = a; z_d_wdata = w;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!z_d_ready && lat < 20);
    chk("ws0 store latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    z_d_req = 1'b0; z_d_we = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; z_reset = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    z_i_req = 1'b0; z_i_addr = '0; z_d_req = 1'b0; z_d_we = 1'b0; z_d_addr = '0; z_d_wdata = '0;
`ifdef BYTE_ENABLE_EN
    d_be = 4'hF; z_d_be = 4'hF;
`endif
    for (int k = 0; k < 4; k++) begin ptime[k] = 0; pport[k] = 1'b0; prd[k] = '0; end

    vecs.push_back(mk(1, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 32'h0000_0104, 32'h12345678, 4'hF, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0000_0004, 32'h0,        4'hF, 32'h12345678));
    vecs.push_back(mk(1, 1, 32'h0000_0008, 32'hCAFEF00D, 4'hF, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0000_0008, 32'h0,        4'hF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 32'h0000_0108, 32'h0,        4'hF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 32'h0000_0013, 32'h01020304, 4'hF, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,        4'hF, 32'h01020304));
    vecs.push_back(mk(0, 0, 32'hFFFF_FF10, 32'h0,        4'hF, 32'h01020304));
    vecs.push_back(mk(1, 1, 32'h0000_0020, 32'h5A5A5A5A, 4'hF, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0000_0020, 32'h0,        4'hF, 32'h5A5A5A5A));
`ifdef BYTE_ENABLE_EN
    vecs.push_back(mk(1, 1, 32'h0000_0030, 32'hAABBCCDD, 4'hF, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0000_0030, 32'h11223344, 4'h5, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0030, 32'h0,        4'hF, 32'hAA22CC44));
    vecs.push_back(mk(0, 0, 32'h0000_0030, 32'h0,        4'hF, 32'hAA22CC44));
`endif

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; z_reset = 1'b0;
    chk("reset i_ready", 32'(i_ready), 32'd0);
    chk("reset d_ready", 32'(d_ready), 32'd0);
    chk("reset i_rdata", i_rdata, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);

    foreach (vecs[k]) run_access(k, vecs[k]);

    // Reset on the commit edge of a store to 0x20 (holds 0x5A5A5A5A)
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort d_ready", 32'(d_ready), 32'd0);
    chk("abort i_ready", 32'(i_ready), 32'd0);
    chk("abort d_rdata", d_rdata, 32'd0);
    chk("abort i_rdata", i_rdata, 32'd0);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    flag = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (d_ready || i_ready) flag = 1'b1;
    end
    chk("abort no late ready", 32'(flag), 32'd0);

    // Both ports held high: data first after reset, then strict alternation
    @(posedge clk); #1;
    i_addr = 32'h08; d_addr = 32'h10; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    np = 0; flag = 1'b0;
    for (int t = 1; t <= 40 && np < 4; t++) begin
      @(posedge clk); #1;
      if (i_ready && d_ready) flag = 1'b1;
      if (i_ready || d_ready) begin
        ptime[np] = t; pport[np] = d_ready; prd[np] = d_ready ? d_rdata : i_rdata;
        np++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("arb both ready", 32'(flag), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arb pulse%0d cycle", k), 32'(ptime[k]), 32'(2 + 3 * k));
      chk($sformatf("arb pulse%0d port_is_d", k), 32'(pport[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("arb pulse%0d rdata", k), prd[k], (k % 2 == 0) ? 32'h01020304 : 32'hCAFEF00D);
    end

    run_access(99, mk(1, 0, 32'h20, 32'h0, 4'hF, 32'h5A5A5A5A));

    // WAIT_STATES=0: back-to-back fetches two cycles apart
    z_store(32'h0, 32'h11111111);
    z_store(32'h4, 32'h22222222);
    @(posedge clk); #1;
    z_i_req = 1'b1; z_i_addr = 32'h0;
    np = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    for (int t = 1; t <= 12 && np < 2; t++) begin
      @(posedge clk); #1;
      if (z_i_ready) begin
        if (np == 0) begin
          t1 = t; r1 = z_i_rdata; z_i_addr = 32'h4;
        end else begin
          t2 = t; r2 = z_i_rdata; z_i_req = 1'b0;
        end
        np++;
      end
    end
    z_i_req = 1'b0;
    chk("ws0 fetch0 cycle", 32'(t1), 32'd1);
    chk("ws0 fetch1 cycle", 32'(t2), 32'd3);
    chk("ws0 fetch0 data", r1, 32'h11111111);
    chk("ws0 fetch1 data", r2, 32'h22222222);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
